// File: rtl/reg_wb_arbiter.sv
// Register-bank write-port scheduler.
// Shares the single bank write port between the ALU writeback path and a FIFO-buffered load
// writeback path. The ALU has priority. A starve counter guarantees forward progress for a
// queued load. A load scoreboard marks destinations of in-flight loads so decode can stall on them.
module reg_wb_arbiter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [3:0]  alu_wa,
    input  logic [31:0] alu_wd,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [3:0]  ld_wa,
    input  logic [31:0] ld_wd,
    output logic        ld_ready,
    input  logic        ld_issue,
    input  logic [3:0]  ld_issue_wa,
    input  logic [3:0]  chk_ra1,
    input  logic [3:0]  chk_ra2,
    input  logic [3:0]  chk_wa,
    output logic        hz_stall,
    output logic [14:0] busy,
    output logic        we3,
    output logic [3:0]  wa3,
    output logic [31:0] wd3,
    output logic        wb_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [3:0]  PC_REG = 4'hF;

    // FIFO storage: {wa, wd}; no reset needed, validity is tracked by count_q
    logic [35:0]    fifo_mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [14:0]    busy_q, busy_d;
    logic           we3_q, we3_d;
    logic [3:0]     wa3_q, wa3_d;
    logic [31:0]    wd3_q, wd3_d;
    logic           err_q, err_d;

    logic           fifo_empty;
    logic           starve;
    logic           alu_grant;
    logic           pop;
    logic           push;
    logic           issue_ok;
    logic [35:0]    head;
    logic [15:0]    busy_ext;

    assign fifo_empty = (count_q == '0);
    assign starve     = !fifo_empty && (wait_q == WW'(MAX_WAIT));
    assign alu_ready  = !starve;
    assign ld_ready   = (count_q < CW'(DEPTH));
    assign alu_grant  = !starve && alu_valid && (alu_wa != PC_REG);
    // Starve implies no ALU grant, so this covers both the preempt and the idle-port pop
    assign pop        = !fifo_empty && !alu_grant;
    assign push       = ld_valid && ld_ready && (ld_wa != PC_REG);
    assign head       = fifo_mem[rd_ptr_q];

    // r15 is never busy, so padding with a zero makes operand 15 contribute nothing
    assign busy_ext   = {1'b0, busy_q};
    assign hz_stall   = busy_ext[chk_ra1] | busy_ext[chk_ra2] | busy_ext[chk_wa];
    assign issue_ok   = ld_issue && (ld_issue_wa != PC_REG) && !busy_ext[ld_issue_wa];

    assign busy   = busy_q;
    assign we3    = we3_q;
    assign wa3    = wa3_q;
    assign wd3    = wd3_q;
    assign wb_err = err_q;

    // Next-state logic: FIFO pointers/count, starve counter, scoreboard, bank port, error pulse
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        wait_d = wait_q;
        if (pop || fifo_empty) begin
            wait_d = '0;
        end else if (wait_q != WW'(MAX_WAIT)) begin
            wait_d = wait_q + WW'(1);
        end

        // Clear applied before set so a same-register set wins
        busy_d = busy_q;
        for (int unsigned r = 0; r < 15; r++) begin
            if (pop && head[35:32] == 4'(r)) begin
                busy_d[r] = 1'b0;
            end
            if (issue_ok && ld_issue_wa == 4'(r)) begin
                busy_d[r] = 1'b1;
            end
        end

        we3_d = alu_grant || pop;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (pop) begin
            wa3_d = head[35:32];
            wd3_d = head[31:0];
        end else if (alu_grant) begin
            wa3_d = alu_wa;
            wd3_d = alu_wd;
        end

        err_d = (alu_valid && alu_wa == PC_REG && alu_ready)
              || (ld_valid && ld_wa == PC_REG && ld_ready)
              || (ld_issue && !issue_ok);
    end

    // Load data capture into the FIFO slot addressed by the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {ld_wa, ld_wd};
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
            busy_q   <= '0;
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            busy_q   <= busy_d;
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Write-port scheduler for the processor register bank (15 writable registers r0–r14; r15 is the PC and is never written).
- Shares the single bank write port (we3/wa3/wd3) between two requesters:
  - the ALU writeback path, which has priority;
  - the load writeback path, which is buffered in a FIFO.
- Keeps a load scoreboard, so decode stalls on registers with an outstanding load.
- Sits between the execute/memory stages and the register bank.

Parameters:
- DEPTH, 4, load FIFO entries (power of two, ≥2)
- MAX_WAIT, 3, cycles a non-empty FIFO head may be bypassed before it preempts the ALU (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU writeback request
- alu_wa  in  4  ALU destination register
- alu_wd  in  32  ALU write data
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- ld_valid  in  1  load writeback request
- ld_wa  in  4  load destination register
- ld_wd  in  32  load data
- ld_ready  out  1  FIFO can accept (combinational, from count only)
- ld_issue  in  1  load issued in decode, mark destination busy
- ld_issue_wa  in  4  destination of issued load
- chk_ra1, chk_ra2, chk_wa  in  4 each  decode operands to check
- hz_stall  out  1  some checked register is busy (combinational)
- busy  out  15  scoreboard bits r0–r14
- we3  out  1  bank write enable (registered)
- wa3  out  4  bank write address (registered)
- wd3  out  32  bank write data (registered)
- wb_err  out  1  one-cycle pulse: illegal request dropped

Behaviour:

Reset (rst=0, asynchronous):
- we3=0, wa3=0, wd3=0, wb_err=0, busy=0.
- FIFO is emptied and the starve counter is cleared.
- Reset asserted mid-operation discards all pending loads.

Output pipeline:
- Bank outputs are registered.
- A grant made in cycle N appears on we3/wa3/wd3 in cycle N+1.
- we3=0 in any cycle that follows a cycle with no grant.

FIFO:
- Push when ld_valid && ld_ready && ld_wa!=15.
- ld_ready = (count < DEPTH); it is not relieved by a same-cycle pop.
- Simultaneous push and pop is legal; the count is then unchanged.
- Pointers wrap modulo DEPTH.

Arbitration each cycle:
- Let starve = (FIFO non-empty && wait_cnt == MAX_WAIT).
- alu_ready = !starve.
- Case 1, starve=1: pop the FIFO head and grant it. The ALU must hold its request.
- Case 2, starve=0, alu_valid=1 and alu_wa!=15: grant the ALU.
- Case 3, starve=0, FIFO non-empty and no ALU grant: pop the head and grant it.
- Case 4: otherwise, no grant.
- A load pushed in cycle N is poppable at N+1 at the earliest. Minimum load latency is 2 cycles (push to we3).

Starve counter:
- wait_cnt increments in each cycle the FIFO is non-empty and the head is not popped.
- It saturates at MAX_WAIT.
- It clears on every pop and whenever the FIFO is empty.

Illegal requests (wa=15):
- An alu_valid with alu_wa=15 while alu_ready=1 is dropped and counts as accepted.
- An ld_valid with ld_wa=15 while ld_ready=1 is dropped and not pushed.
- Either case gives wb_err=1 in the next cycle.
- Two illegal requests in the same cycle give a single pulse.

Scoreboard:
- ld_issue with ld_issue_wa!=15 and busy bit clear: set busy[ld_issue_wa] at the next edge.
- ld_issue to an already-busy register, or to r15: ignored, wb_err pulse.
- A FIFO grant clears busy[wa] at the edge that registers the grant (the same edge that loads we3).
- Set and clear of the same register in the same cycle: set wins.
- ALU grants never change busy.
- hz_stall = busy[chk_ra1] | busy[chk_ra2] | busy[chk_wa], where any operand equal to 15 contributes 0.

Data:
- wd3 carries the selected requester's 32-bit data unmodified.

Test Plan:
1. Reset, then alu_valid=1, alu_wa=3, alu_wd=0xDEADBEEF for one cycle -> next cycle we3=1, wa3=3, wd3=0xDEADBEEF; following cycle we3=0.
2. Contention: ld_issue wa=5, then ld_valid wa=5 wd=0x11 at cycle N, with alu_valid wa=2 at N+1 -> busy[5]=1, hz_stall=1 for chk_ra1=5; we3 writes r2 at N+2, r5 (0x11) at N+3; busy[5]=0 from N+3.
3. Starvation: ALU valid every cycle, one load queued -> after MAX_WAIT=3 bypassed cycles alu_ready=0 for one cycle; the load is written next; the held ALU write lands the cycle after.
4. Full FIFO: push 4 loads while the ALU saturates the port -> ld_ready=0 with count=4; a 5th ld_valid is not accepted; pointers wrap correctly over 8 total pushes, written in order.
5. Illegal requests: alu_wa=15, then ld_wa=15, then ld_issue to a busy r7 -> no write; wb_err pulses each time; busy unchanged.
6. rst=0 asynchronously with 3 loads queued and busy[1,4]=1 -> we3, busy and count go to 0 immediately, without a clock edge; after release no stale writes occur.
